// File: rtl/arith_sched_pkg.sv
// Shared types for the round-robin arithmetic scheduler.
// Opcodes, FSM states and the per-op iteration count.
package arith_sched_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3,
        OP_GT  = 3'd4,
        OP_GE  = 3'd5,
        OP_LT  = 3'd6,
        OP_LE  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Iterative ops take one cycle per operand bit.
    function automatic int unsigned cycles_for(
        input op_e         op,
        input int unsigned width
    );
        case (op)
            OP_MUL, OP_DIV: return width;
            default:        return 1;
        endcase
    endfunction

endpackage

// File: rtl/arith_iter_core.sv
// Iterative datapath: single-cycle add/sub/compare,
// LSB-first shift-add multiply, MSB-first restoring divide.
module arith_iter_core
    import arith_sched_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  op_e                op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] y,
    output logic               dbz
);

    localparam int CW = $clog2(WIDTH) + 1;

    op_e                op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               run_q, run_d;

    logic               last;
    logic [2*WIDTH-1:0] prod_n;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
    logic               qbit;
    logic [WIDTH-1:0]   rem_n;
    logic [WIDTH-1:0]   quo_n;

    always_comb begin
        last    = (cnt_q == CW'(cycles_for(op_q, WIDTH) - 1));
        prod_n  = acc_q + (mplier_q[0] ? mcand_q : '0);
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, b_q};
        // No borrow means the divisor fits: keep the difference.
        qbit    = ~trial[WIDTH];
        rem_n   = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_n   = {quo_q[WIDTH-2:0], qbit};
        done    = run_q && last;
    end

    always_comb begin
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        if (start) begin
            op_d     = op;
            a_d      = a;
            b_d      = b;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            rem_d    = '0;
            quo_d    = a;
            cnt_d    = '0;
            run_d    = 1'b1;
        end else if (run_q) begin
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            acc_d    = prod_n;
            rem_d    = rem_n;
            quo_d    = quo_n;
            cnt_d    = cnt_q + CW'(1);
            run_d    = !last;
        end
    end

    always_comb begin
        y = '0;
        unique case (op_q)
            OP_ADD: y = {{WIDTH{1'b0}}, a_q + b_q};
            OP_SUB: y = {{WIDTH{1'b0}}, a_q - b_q};
            OP_MUL: y = prod_n;
            OP_DIV: y = {rem_n, quo_n};
            OP_GT:  y = {{(2*WIDTH-1){1'b0}}, a_q >  b_q};
            OP_GE:  y = {{(2*WIDTH-1){1'b0}}, a_q >= b_q};
            OP_LT:  y = {{(2*WIDTH-1){1'b0}}, a_q <  b_q};
            OP_LE:  y = {{(2*WIDTH-1){1'b0}}, a_q <= b_q};
        endcase
        dbz = (op_q == OP_DIV) && (b_q == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else begin
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
        end
    end

endmodule

// File: rtl/arith_rr_sched.sv
// Round-robin front end sharing one iterative arithmetic core
// between NUM_REQ requesters; holds arbiter, FSM and response regs.
module arith_rr_sched
    import arith_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [3*NUM_REQ-1:0]       req_op,
    input  logic [WIDTH*NUM_REQ-1:0]   req_a,
    input  logic [WIDTH*NUM_REQ-1:0]   req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [2*WIDTH-1:0]         rsp_y,
    output logic                       rsp_dbz,
    output logic                       busy
);

    localparam int IW = $clog2(NUM_REQ);

    state_e             state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      id_q, id_d;
    logic [2*WIDTH-1:0] y_q, y_d;
    logic               dbz_q, dbz_d;

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [IW-1:0]        off;
    logic [IW:0]          sum;
    logic [IW:0]          nxt;
    logic                 grant_any;
    logic [IW-1:0]        grant_idx;
    logic [IW-1:0]        ptr_nxt;

    logic               core_start;
    op_e                core_op;
    logic [WIDTH-1:0]   core_a;
    logic [WIDTH-1:0]   core_b;
    logic               core_done;
    logic [2*WIDTH-1:0] core_y;
    logic               core_dbz;

    // Rotate so the pointer sits at bit 0, then take the lowest set bit.
    always_comb begin
        dbl = {req_valid, req_valid} >> ptr_q;
        rot = dbl[NUM_REQ-1:0];
        off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) off = IW'(k);
        end
        grant_any = |req_valid;
        sum = {1'b0, ptr_q} + {1'b0, off};
        if (sum >= (IW+1)'(NUM_REQ)) sum = sum - (IW+1)'(NUM_REQ);
        grant_idx = sum[IW-1:0];
        nxt = {1'b0, grant_idx} + (IW+1)'(1);
        if (nxt == (IW+1)'(NUM_REQ)) nxt = '0;
        ptr_nxt = nxt[IW-1:0];
    end

    always_comb begin
        core_op = op_e'(req_op[3*grant_idx +: 3]);
        core_a  = req_a[WIDTH*grant_idx +: WIDTH];
        core_b  = req_b[WIDTH*grant_idx +: WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            y_q     <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            y_q     <= y_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        y_d     = y_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            IDLE: begin
                if (grant_any) begin
                    state_d = EXEC;
                    ptr_d   = ptr_nxt;
                    id_d    = grant_idx;
                end
            end
            EXEC: begin
                if (core_done) begin
                    state_d = RESP;
                    y_d     = core_y;
                    dbz_d   = core_dbz;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Gated by rst_n so no accept is offered while reset is held.
    always_comb begin
        core_start = rst_n && (state_q == IDLE) && grant_any;
        req_ready  = core_start ? (NUM_REQ'(1) << grant_idx) : '0;
        rsp_valid  = (state_q == RESP);
        busy       = (state_q != IDLE);
        rsp_id     = id_q;
        rsp_y      = y_q;
        rsp_dbz    = dbz_q;
    end

    arith_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .start (core_start),
        .op    (core_op),
        .a     (core_a),
        .b     (core_b),
        .done  (core_done),
        .y     (core_y),
        .dbz   (core_dbz)
    );

endmodule

// File: tb/tb_arith_rr_sched.sv
// Directed bench for arith_rr_sched: latency, results,
// divide-by-zero, rotation order, backpressure and reset.
module tb_arith_rr_sched;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [3*N-1:0] req_op;
    logic [W*N-1:0] req_a;
    logic [W*N-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [2*W-1:0] rsp_y;
    logic           rsp_dbz;
    logic           busy;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    arith_rr_sched #(
        .NUM_REQ (N),
        .WIDTH   (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .rsp_dbz   (rsp_dbz),
        .busy      (busy)
    );

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        req_op[3*id +: 3] = op;
        req_a[W*id +: W]  = a;
        req_b[W*id +: W]  = b;
        req_valid[id]     = 1'b1;
    endtask

    task automatic wait_rsp(input string tag, input int lat,
                            input logic [63:0] ey, input int eid,
                            input logic edbz);
        int edges;
        logic ok;
        edges = 0;
        ok = 1'b0;
        for (int e = 1; e <= 100; e++) begin
            @(posedge clk); #1;
            if (rsp_valid) begin
                edges = e;
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_rsp"}, ok, 1);
        check({tag, "_lat"}, edges, lat);
        check({tag, "_y"}, rsp_y, ey);
        check({tag, "_id"}, rsp_id, eid);
        check({tag, "_dbz"}, rsp_dbz, edbz);
    endtask

    task automatic run_op(input string tag, input int id,
                          input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [63:0] ey,
                          input logic edbz);
        logic ok;
        @(negedge clk);
        set_req(id, op, a, b);
        #1;
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (req_ready[id]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        check({tag, "_grant"}, ok, 1);
        if (!ok) begin
            req_valid[id] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        wait_rsp(tag, lat, ey, id, edbz);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int   grants [5];
        int   ng;
        int   bad;
        logic seen;
        logic ok;

        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        req_valid[1] = 1'b1;
        #12;
        check("rst_ready", req_ready, 0);
        check("rst_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_y", rsp_y, 0);
        check("rst_id", rsp_id, 0);
        check("rst_dbz", rsp_dbz, 0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a multiply.
        @(negedge clk);
        set_req(0, 3'd2, 32'd7, 32'd9);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (4) @(posedge clk);
        #2;
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", rsp_valid, 0);
        check("mid_rst_ready", req_ready, 0);
        check("mid_rst_y", rsp_y, 0);
        check("mid_rst_id", rsp_id, 0);
        check("mid_rst_dbz", rsp_dbz, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("mid_no_rsp", seen, 0);

        run_op("add", 0, 3'd0, 32'hFFFF_FFFF, 32'd2, 1,
               64'h1, 1'b0);
        run_op("sub", 0, 3'd1, 32'd3, 32'd5, 1,
               64'h0000_0000_FFFF_FFFE, 1'b0);
        run_op("mul", 0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32,
               64'hFFFF_FFFE_0000_0001, 1'b0);
        run_op("div", 0, 3'd3, 32'd100, 32'd7, 32,
               64'h0000_0002_0000_000E, 1'b0);
        run_op("dbz", 0, 3'd3, 32'd55, 32'd0, 32,
               64'h0000_0037_FFFF_FFFF, 1'b1);
        run_op("le", 0, 3'd7, 32'd4, 32'd4, 1, 64'h1, 1'b0);
        run_op("gt0", 0, 3'd4, 32'd3, 32'd5, 1, 64'h0, 1'b0);

        // Round robin from a freshly reset pointer.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < N; i++) set_req(i, 3'd4, 32'd5, 32'd3);
        rsp_ready = 1'b1;
        ng = 0;
        bad = 0;
        ok = 1'b1;
        for (int c = 0; c < 60 && ng < 5; c++) begin
            #1;
            if (!$onehot0(req_ready)) ok = 1'b0;
            if (rsp_valid && rsp_y !== 64'h1) bad++;
            for (int i = 0; i < N; i++) begin
                if (req_ready[i] && ng < 5) begin
                    grants[ng] = i;
                    ng++;
                end
            end
            if (ng < 5) @(negedge clk);
        end
        @(posedge clk); #1;
        req_valid = '0;
        for (int c = 0; c < 10 && busy; c++) begin
            @(negedge clk);
            if (rsp_valid && rsp_y !== 64'h1) bad++;
        end
        rsp_ready = 1'b0;
        check("rr_count", ng, 5);
        check("rr_onehot", ok, 1);
        check("rr_y", bad, 0);
        check("rr_g0", grants[0], 0);
        check("rr_g1", grants[1], 1);
        check("rr_g2", grants[2], 2);
        check("rr_g3", grants[3], 3);
        check("rr_g4", grants[4], 0);

        // Backpressure: response held while requester 3 waits.
        @(negedge clk);
        set_req(1, 3'd0, 32'd10, 32'd20);
        #1;
        check("bp_grant1", req_ready, 4'b0010);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        set_req(3, 3'd0, 32'd1, 32'd2);
        wait_rsp("bp1", 1, 64'd30, 1, 1'b0);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_y !== 64'd30 ||
                rsp_id !== 2'd1 || req_ready !== 4'b0000) bad++;
        end
        check("bp_stable", bad, 0);
        rsp_ready = 1'b1;
        #1;
        check("bp_hs_ready", req_ready, 0);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("bp_hs_valid", rsp_valid, 0);
        @(negedge clk); #1;
        check("bp_grant3", req_ready, 4'b1000);
        @(posedge clk); #1;
        req_valid[3] = 1'b0;
        wait_rsp("bp3", 1, 64'd3, 3, 1'b0);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("bp_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
